// File: rtl/itcm_fetch_responder.sv
// itcm_fetch_responder
//   Tightly-coupled instruction memory acting as the responder for the fetch
//   unit. Requests are taken with a valid/ready handshake, decoded, and their
//   responses queued in a two-entry FIFO. The FIFO head drives the response
//   port. A byte-strobed write port loads the program image.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_req_valid/addr      fetch request (byte address)
//   o_req_ready           request accepted when valid & ready
//   o_resp_valid/addr/data, o_resp_load_fault, o_resp_page_fault_x
//                         head of the response queue
//   i_resp_ready          response consumed when valid & ready
//   i_exec_lock           forbids execution from this memory
//   i_wr_valid/addr/data/strb  preload write (word index, byte enables)
module itcm_fetch_responder #(
  parameter int unsigned abits      = 64,
  parameter int unsigned log2_words = 10,
  parameter logic [63:0] base_addr  = 64'h0000_0000_0001_0000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  input  logic [abits-1:0]      i_req_addr,
  output logic                  o_req_ready,
  output logic                  o_resp_valid,
  output logic [abits-1:0]      o_resp_addr,
  output logic [63:0]           o_resp_data,
  output logic                  o_resp_load_fault,
  output logic                  o_resp_page_fault_x,
  input  logic                  i_resp_ready,
  input  logic                  i_exec_lock,
  input  logic                  i_wr_valid,
  input  logic [log2_words-1:0] i_wr_addr,
  input  logic [63:0]           i_wr_data,
  input  logic [7:0]            i_wr_strb
);

  localparam int unsigned      depth = 1 << log2_words;
  localparam logic [abits-1:0] base  = base_addr[abits-1:0];

  logic [63:0] mem [depth];
  logic [63:0] mem_q_reg;

  logic [1:0]  count_reg;
  logic [1:0]  count_next;
  logic        rd_ptr_reg;
  logic        wr_ptr_reg;

  // The RAM read is registered, so the data of an entry pushed in cycle N
  // lands in its slot one cycle later. These registers describe that
  // outstanding fill.
  logic        fill_pending_reg;
  logic        fill_slot_reg;
  logic        fill_zero_reg;
  logic [2:0]  fill_shift_reg;
  logic [63:0] fill_data;
  logic        head_fill;

  logic [abits-1:0] off;
  logic             dec_lf;
  logic             dec_pf;
  logic             push;
  logic             pop;

  // Decode. The unsigned subtraction makes addresses below base or wrapping
  // around the top of the address space appear as huge offsets.
  assign off    = i_req_addr - base;
  assign dec_lf = (i_req_addr < base) | (|off[abits-1:log2_words+3]) | i_req_addr[0];
  assign dec_pf = ~dec_lf & i_exec_lock;

  // Ready depends on the registered count only.
  assign o_req_ready  = (count_reg != 2'd2);
  assign o_resp_valid = (count_reg != 2'd0);
  assign push         = i_req_valid & o_req_ready;
  assign pop          = o_resp_valid & i_resp_ready;
  assign count_next   = count_reg + {1'b0, push} - {1'b0, pop};

  // Byte-enabled RAM with registered read. The read samples the old word when
  // a write to the same word happens in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_wr_valid) begin
      for (int k = 0; k < 8; k++) begin
        if (i_wr_strb[k]) begin
          mem[i_wr_addr][8*k +: 8] <= i_wr_data[8*k +: 8];
        end
      end
    end
    if (push) begin
      mem_q_reg <= mem[off[log2_words+2:3]];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_reg        <= 2'd0;
      rd_ptr_reg       <= 1'b0;
      wr_ptr_reg       <= 1'b0;
      fill_pending_reg <= 1'b0;
      fill_slot_reg    <= 1'b0;
      fill_zero_reg    <= 1'b0;
      fill_shift_reg   <= 3'd0;
    end else begin
      count_reg        <= count_next;
      fill_pending_reg <= push;
      if (push) begin
        wr_ptr_reg     <= ~wr_ptr_reg;
        fill_slot_reg  <= wr_ptr_reg;
        fill_zero_reg  <= dec_lf | dec_pf;
        fill_shift_reg <= off[2:0];
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
    end
  end

  // Faulted entries carry zero data; otherwise the word is shifted down so
  // the addressed byte sits in bits [7:0], upper bytes zero-filled.
  assign fill_data = fill_zero_reg ? 64'd0 : (mem_q_reg >> {fill_shift_reg, 3'b000});

  // Queue slots. A slot is never pushed while its own fill is outstanding:
  // consecutive pushes alternate slots.
  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_slot
    logic [abits-1:0] addr_reg;
    logic [63:0]      data_reg;
    logic             lf_reg;
    logic             pf_reg;

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        addr_reg <= '0;
        data_reg <= 64'd0;
        lf_reg   <= 1'b0;
        pf_reg   <= 1'b0;
      end else begin
        if (push && (wr_ptr_reg == 1'(gi))) begin
          addr_reg <= i_req_addr;
          lf_reg   <= dec_lf;
          pf_reg   <= dec_pf;
        end
        if (fill_pending_reg && (fill_slot_reg == 1'(gi))) begin
          data_reg <= fill_data;
        end
      end
    end
  end

  // While the head's fill is still outstanding its data comes straight from
  // the RAM output register; the slot holds the same value afterwards, so the
  // head stays stable across the handover.
  assign head_fill           = fill_pending_reg & (fill_slot_reg == rd_ptr_reg);
  assign o_resp_addr         = rd_ptr_reg ? g_slot[1].addr_reg : g_slot[0].addr_reg;
  assign o_resp_data         = head_fill ? fill_data
                             : (rd_ptr_reg ? g_slot[1].data_reg : g_slot[0].data_reg);
  assign o_resp_load_fault   = rd_ptr_reg ? g_slot[1].lf_reg : g_slot[0].lf_reg;
  assign o_resp_page_fault_x = rd_ptr_reg ? g_slot[1].pf_reg : g_slot[0].pf_reg;

  a_no_push_when_full: assert property (@(posedge i_clk) disable iff (i_rst)
    !(push && (count_reg == 2'd2)));

endmodule

// File: tb/tb_itcm_fetch_responder.sv
module tb_itcm_fetch_responder;

  localparam int unsigned ABITS = 64;
  localparam int unsigned LOG2W = 10;
  localparam int unsigned WORDS = 1 << LOG2W;
  localparam logic [63:0] BASE  = 64'h0000_0000_0001_0000;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic [ABITS-1:0] req_addr = '0;
  logic             req_ready;
  logic             resp_valid;
  logic [ABITS-1:0] resp_addr;
  logic [63:0]      resp_data;
  logic             resp_lf;
  logic             resp_pf;
  logic             resp_ready = 1'b0;
  logic             exec_lock = 1'b0;
  logic             wr_valid = 1'b0;
  logic [LOG2W-1:0] wr_addr = '0;
  logic [63:0]      wr_data = '0;
  logic [7:0]       wr_strb = '0;

  int passed = 0;
  int total  = 0;

  itcm_fetch_responder #(
    .abits(ABITS), .log2_words(LOG2W), .base_addr(BASE)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .i_req_addr(req_addr), .o_req_ready(req_ready),
    .o_resp_valid(resp_valid), .o_resp_addr(resp_addr), .o_resp_data(resp_data),
    .o_resp_load_fault(resp_lf), .o_resp_page_fault_x(resp_pf),
    .i_resp_ready(resp_ready), .i_exec_lock(exec_lock),
    .i_wr_valid(wr_valid), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_wr_strb(wr_strb)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    logic        lf;
    logic        pf;
  } resp_t;

  logic [63:0] mem_m [WORDS];
  resp_t       q[$];

  function automatic resp_t model_resp(logic [63:0] a, logic lock);
    resp_t       r;
    logic [63:0] o;
    r.addr = a; r.data = 64'd0; r.lf = 1'b0; r.pf = 1'b0;
    o = a - BASE;
    if (a < BASE || o >= 64'(8 * WORDS) || a[0]) r.lf = 1'b1;
    else if (lock) r.pf = 1'b1;
    else r.data = mem_m[int'(o / 8)] >> (8 * (o % 8));
    return r;
  endfunction

  // Advance one clock, updating the model from the inputs currently driven.
  task automatic clock_cycle();
    resp_t e;
    bit    acc;
    bit    pp;
    acc = req_valid && (q.size() < 2);
    pp  = (q.size() != 0) && resp_ready;
    if (acc) e = model_resp(req_addr, exec_lock);
    if (wr_valid) begin
      for (int k = 0; k < 8; k++)
        if (wr_strb[k]) mem_m[wr_addr][8*k +: 8] = wr_data[8*k +: 8];
    end
    if (rst) begin
      q.delete();
    end else begin
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(int idx, logic [63:0] d, logic [7:0] s);
    wr_valid = 1'b1; wr_addr = LOG2W'(idx); wr_data = d; wr_strb = s;
    clock_cycle();
    wr_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    clock_cycle();
    clock_cycle();
    total++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_lf !== 1'b0 || resp_pf !== 1'b0 ||
        resp_addr !== 64'd0 || resp_data !== 64'd0)
      $display("FAIL reset_state got valid=%b ready=%b lf=%b pf=%b addr=%h data=%h exp 0 1 0 0 0 0",
               resp_valid, req_ready, resp_lf, resp_pf, resp_addr, resp_data);
    else passed++;
    rst = 1'b0;
    $display("txn reset done");
  endtask

  task automatic test_basic();
    write_word(0, 64'h1122_3344_5566_7788, 8'hFF);
    resp_ready = 1'b0; req_valid = 1'b1; req_addr = BASE;
    clock_cycle();
    req_valid = 1'b0;
    total++;
    if (resp_valid !== 1'b1 || resp_data !== 64'h1122_3344_5566_7788 || resp_addr !== BASE ||
        resp_lf !== 1'b0 || resp_pf !== 1'b0)
      $display("FAIL basic_word0 got valid=%b addr=%h data=%h lf=%b pf=%b exp 1 %h 1122334455667788 0 0",
               resp_valid, resp_addr, resp_data, resp_lf, resp_pf, BASE);
    else passed++;
    $display("txn rsp addr=%h data=%h", resp_addr, resp_data);

    resp_ready = 1'b1; req_valid = 1'b1; req_addr = BASE + 64'd6;
    clock_cycle();
    total++;
    if (resp_valid !== 1'b1 || resp_data !== 64'h1122 || resp_addr !== BASE + 64'd6 || resp_lf !== 1'b0)
      $display("FAIL basic_shift got valid=%b addr=%h data=%h lf=%b exp 1 %h 1122 0",
               resp_valid, resp_addr, resp_data, resp_lf, BASE + 64'd6);
    else passed++;
    $display("txn rsp addr=%h data=%h", resp_addr, resp_data);

    req_addr = BASE + 64'd3;
    clock_cycle();
    total++;
    if (resp_valid !== 1'b1 || resp_lf !== 1'b1 || resp_pf !== 1'b0 || resp_data !== 64'd0)
      $display("FAIL basic_misaligned got valid=%b lf=%b pf=%b data=%h exp 1 1 0 0",
               resp_valid, resp_lf, resp_pf, resp_data);
    else passed++;
    $display("txn rsp addr=%h lf=%b", resp_addr, resp_lf);

    req_valid = 1'b0;
    clock_cycle();
    total++;
    if (resp_valid !== 1'b0) $display("FAIL basic_drain got valid=%b exp 0", resp_valid);
    else passed++;
  endtask

  task automatic test_faults();
    logic [63:0] addrs [7] = '{64'h0000_FFF0, 64'h0001_2000, 64'h0001_0008, 64'h0001_1FF8,
                               64'h0001_1FFF, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0001_0001};
    logic        locks [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic        exp_lf[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic        exp_pf[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    resp_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      req_valid = 1'b1; req_addr = addrs[i]; exec_lock = locks[i];
      clock_cycle();
      total++;
      if (resp_valid !== 1'b1 || resp_addr !== addrs[i] || resp_lf !== exp_lf[i] ||
          resp_pf !== exp_pf[i] || resp_data !== 64'd0)
        $display("FAIL fault_%0d got valid=%b addr=%h lf=%b pf=%b data=%h exp 1 %h %b %b 0",
                 i, resp_valid, resp_addr, resp_lf, resp_pf, resp_data, addrs[i], exp_lf[i], exp_pf[i]);
      else passed++;
      $display("txn rsp addr=%h lf=%b pf=%b", resp_addr, resp_lf, resp_pf);
    end
    req_valid = 1'b0; exec_lock = 1'b0;
    clock_cycle();
  endtask

  task automatic test_back_to_back();
    for (int i = 2; i < 6; i++) write_word(i, 64'hC0DE_0000_0000_0000 | 64'(i), 8'hFF);
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_addr = BASE + 64'(8 * (i + 2));
      total++;
      if (req_ready !== 1'b1) $display("FAIL b2b_ready_%0d got %b exp 1", i, req_ready);
      else passed++;
      clock_cycle();
      total++;
      if (resp_valid !== 1'b1 || resp_addr !== BASE + 64'(8 * (i + 2)) ||
          resp_data !== (64'hC0DE_0000_0000_0000 | 64'(i + 2)))
        $display("FAIL b2b_rsp_%0d got valid=%b addr=%h data=%h exp 1 %h %h", i, resp_valid,
                 resp_addr, resp_data, BASE + 64'(8 * (i + 2)), 64'hC0DE_0000_0000_0000 | 64'(i + 2));
      else passed++;
      $display("txn rsp addr=%h data=%h", resp_addr, resp_data);
    end
    req_valid = 1'b0;
    clock_cycle();
    total++;
    if (resp_valid !== 1'b0) $display("FAIL b2b_drain got valid=%b exp 0", resp_valid);
    else passed++;
  endtask

  task automatic test_backpressure();
    resp_ready = 1'b0; req_valid = 1'b1; req_addr = BASE + 64'd16;
    clock_cycle();
    req_addr = BASE + 64'd24;
    clock_cycle();
    total++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b1 || resp_addr !== BASE + 64'd16 ||
        resp_data !== 64'hC0DE_0000_0000_0002)
      $display("FAIL bp_full got ready=%b valid=%b addr=%h data=%h exp 0 1 %h c0de000000000002",
               req_ready, resp_valid, resp_addr, resp_data, BASE + 64'd16);
    else passed++;
    // Requester changes the address while stalled; only the one at accept counts.
    for (int i = 0; i < 2; i++) begin
      req_addr = (i == 0) ? BASE + 64'd40 : BASE + 64'd32;
      clock_cycle();
      total++;
      if (req_ready !== 1'b0 || resp_addr !== BASE + 64'd16 || resp_data !== 64'hC0DE_0000_0000_0002)
        $display("FAIL bp_hold_%0d got ready=%b addr=%h data=%h exp 0 %h c0de000000000002",
                 i, req_ready, resp_addr, resp_data, BASE + 64'd16);
      else passed++;
    end
    resp_ready = 1'b1;
    clock_cycle();
    total++;
    if (req_ready !== 1'b1 || resp_addr !== BASE + 64'd24 || resp_data !== 64'hC0DE_0000_0000_0003)
      $display("FAIL bp_drain1 got ready=%b addr=%h data=%h exp 1 %h c0de000000000003",
               req_ready, resp_addr, resp_data, BASE + 64'd24);
    else passed++;
    $display("txn rsp addr=%h data=%h", resp_addr, resp_data);
    clock_cycle();
    req_valid = 1'b0;
    total++;
    if (resp_valid !== 1'b1 || resp_addr !== BASE + 64'd32 || resp_data !== 64'hC0DE_0000_0000_0004)
      $display("FAIL bp_third got valid=%b addr=%h data=%h exp 1 %h c0de000000000004",
               resp_valid, resp_addr, resp_data, BASE + 64'd32);
    else passed++;
    $display("txn rsp addr=%h data=%h", resp_addr, resp_data);
    clock_cycle();
    total++;
    if (resp_valid !== 1'b0) $display("FAIL bp_empty got valid=%b exp 0", resp_valid);
    else passed++;
  endtask

  task automatic test_rbw();
    write_word(1, 64'h0123_4567_89AB_CDEF, 8'hFF);
    resp_ready = 1'b1;
    wr_valid = 1'b1; wr_addr = LOG2W'(1); wr_data = 64'hAAAA_AAAA_AAAA_AAAA; wr_strb = 8'h0F;
    req_valid = 1'b1; req_addr = BASE + 64'd8;
    clock_cycle();
    wr_valid = 1'b0;
    total++;
    if (resp_data !== 64'h0123_4567_89AB_CDEF)
      $display("FAIL rbw_old got %h exp 0123456789abcdef", resp_data);
    else passed++;
    clock_cycle();
    total++;
    if (resp_data !== 64'h0123_4567_AAAA_AAAA)
      $display("FAIL rbw_new got %h exp 01234567aaaaaaaa", resp_data);
    else passed++;
    $display("txn rsp addr=%h data=%h", resp_addr, resp_data);
    // A queued entry keeps its data when the word is rewritten afterwards.
    resp_ready = 1'b0;
    clock_cycle();
    req_valid = 1'b0;
    write_word(1, 64'h5555_5555_5555_5555, 8'hFF);
    total++;
    if (resp_valid !== 1'b1 || resp_data !== 64'h0123_4567_AAAA_AAAA)
      $display("FAIL rbw_queued got valid=%b data=%h exp 1 01234567aaaaaaaa", resp_valid, resp_data);
    else passed++;
    resp_ready = 1'b1;
    clock_cycle();
    clock_cycle();
  endtask

  task automatic test_reset_mid();
    resp_ready = 1'b0; req_valid = 1'b1; req_addr = BASE;
    clock_cycle();
    clock_cycle();
    total++;
    if (resp_valid !== 1'b1 || req_ready !== 1'b0)
      $display("FAIL rstmid_full got valid=%b ready=%b exp 1 0", resp_valid, req_ready);
    else passed++;
    rst = 1'b1; req_valid = 1'b0;
    clock_cycle();
    rst = 1'b0;
    total++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL rstmid_cleared got valid=%b ready=%b exp 0 1", resp_valid, req_ready);
    else passed++;
    clock_cycle();
    total++;
    if (resp_valid !== 1'b0) $display("FAIL rstmid_after got valid=%b exp 0", resp_valid);
    else passed++;
    $display("txn reset mid-operation");
  endtask

  task automatic test_random();
    int sel;
    for (int i = 0; i < 16; i++) write_word(i, {$urandom, $urandom}, 8'hFF);
    for (int cyc = 0; cyc < 400; cyc++) begin
      total++;
      if (req_ready !== (q.size() < 2))
        $display("FAIL rnd_ready cyc=%0d got %b exp %b", cyc, req_ready, q.size() < 2);
      else passed++;
      total++;
      if (resp_valid !== (q.size() != 0))
        $display("FAIL rnd_valid cyc=%0d got %b exp %b", cyc, resp_valid, q.size() != 0);
      else passed++;
      if (q.size() != 0) begin
        total++;
        if (resp_addr !== q[0].addr || resp_data !== q[0].data ||
            resp_lf !== q[0].lf || resp_pf !== q[0].pf)
          $display("FAIL rnd_head cyc=%0d got addr=%h data=%h lf=%b pf=%b exp %h %h %b %b", cyc,
                   resp_addr, resp_data, resp_lf, resp_pf, q[0].addr, q[0].data, q[0].lf, q[0].pf);
        else passed++;
      end
      rst        = ($urandom_range(0, 99) < 2);
      resp_ready = ($urandom_range(0, 9) < 6);
      req_valid  = ($urandom_range(0, 9) < 7);
      exec_lock  = ($urandom_range(0, 9) == 0);
      sel = int'($urandom_range(0, 9));
      if (sel <= 6)      req_addr = BASE + 64'($urandom_range(0, 127));
      else if (sel == 7) req_addr = BASE - 64'($urandom_range(1, 64));
      else if (sel == 8) req_addr = BASE + 64'(8 * WORDS) + 64'($urandom_range(0, 64));
      else               req_addr = 64'hFFFF_FFFF_0000_0000 | 64'($urandom);
      wr_valid = ($urandom_range(0, 9) < 3);
      wr_addr  = LOG2W'($urandom_range(0, 15));
      wr_data  = {$urandom, $urandom};
      wr_strb  = 8'($urandom);
      if (!rst && resp_ready && q.size() != 0)
        $display("txn rsp addr=%h data=%h lf=%b pf=%b", resp_addr, resp_data, resp_lf, resp_pf);
      clock_cycle();
    end
    rst = 1'b0; req_valid = 1'b0; wr_valid = 1'b0; exec_lock = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_faults();
    test_back_to_back();
    test_backpressure();
    test_rbw();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
